pir_array_monitor: RTL and testbench
====================================

# pir_array_monitor

Parametrised multi-channel PIR motion monitor: next generation of the three-sensor alarm controller. Each of NUM_CH sensor channels is sampled on a programmable strobe and averaged over a power-of-two window. Any channel average at or above THRESHOLD raises a timed alarm. Statistics (peak, last trigger, trigger count) are kept across enable cycles, and every alarm event is pushed into a readable event-log FIFO. The block sits between the PIR sensor front-ends and the LED/buzzer/display logic.

## Interface
- NUM_CH, 3, number of sensor channels (1..8)
- SAMPLE_W, 7, sensor sample width in bits
- AVG_LOG2, 2, log2 of averaging window length (window = 2^AVG_LOG2 samples)
- SAMPLE_DIV, 3, clocks per sample strobe (>=1)
- THRESHOLD, 50, trigger level; a channel triggers when avg >= THRESHOLD
- ALARM_CYCLES, 100, buzzer duration in clocks
- LOG_DEPTH, 8, event-log FIFO depth (power of two)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = monitor, 0 = off
- stop_alarm  in  1  terminates an active alarm
- sensor_data  in  NUM_CH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W]
- led  out  NUM_CH  per-channel trigger indicator during alarm
- buzzer  out  1  alarm active
- avg_out  out  NUM_CH*SAMPLE_W  latest completed window averages
- avg_valid  out  1  one-cycle pulse: avg_out just updated
- peak_value / peak_ch  out  SAMPLE_W / 3  largest triggering average since reset, and its channel
- last_value / last_ch  out  SAMPLE_W / 3  average and channel of the most recent trigger
- trigger_count  out  16  total triggered channels since reset, saturating at 0xFFFF
- log_rd_en  in  1  pop log head
- log_rd_data  out  NUM_CH+SAMPLE_W  head entry {mask, event_max}, first-word-fall-through
- log_empty  out  1  log holds no entries
- log_level  out  $clog2(LOG_DEPTH+1)  number of entries in the log
- log_overflow  out  1  sticky: an event was dropped

## Operation
- States: OFF, MONITOR, ALARM, CLEAR. Reset puts the block in OFF with every output, accumulator, counter and log pointer at 0.
- OFF: if enable = 1, go to MONITOR next edge.
- MONITOR:
  - Sample counter runs 0..SAMPLE_DIV-1. The strobe fires when the counter equals SAMPLE_DIV-1.
  - On each strobe, every channel's sample is added to its accumulator (SAMPLE_W+AVG_LOG2 bits, cannot overflow).
  - On the 2^AVG_LOG2-th strobe (the edge that includes that sample):
    - avg_out[c] <= (acc[c] + sample[c]) >> AVG_LOG2, truncating;
    - accumulators clear; avg_valid = 1 for the following cycle.
  - In the avg_valid cycle, mask[c] = (avg_out[c] >= THRESHOLD).
  - If mask != 0, at the next edge:
    - go to ALARM; led <= mask; buzzer <= 1;
    - trigger_count += popcount(mask), saturating;
    - last_* <= highest-index triggered channel;
    - event_max = largest triggered average, lowest index on ties; if event_max > peak_value, update peak_*;
    - push {mask, event_max} into the log.
  - enable = 0 in MONITOR: go to CLEAR.
- ALARM:
  - Sampling is suspended.
  - Alarm counter increments each cycle; buzzer stays 1 for exactly ALARM_CYCLES cycles, then go to CLEAR.
  - stop_alarm = 1 or enable = 0 goes to CLEAR at the next edge. This has priority over the counter.
- CLEAR (one cycle):
  - led, buzzer, accumulators, sample counter and alarm counter go to 0.
  - Next state is MONITOR if enable = 1, else OFF.
  - avg_out is held.
- Retention: peak_*, last_*, trigger_count, the log and log_overflow change only through rst_n or log reads, never through enable.
- Log FIFO:
  - Pop when log_rd_en && !log_empty; log_rd_en while empty is ignored.
  - Push when full without a same-cycle pop: entry dropped, log_overflow <= 1.
  - Push and pop in the same cycle with the log full: both succeed, level unchanged.
  - Pointers wrap modulo LOG_DEPTH.
- rst_n asserted in any state (including mid-alarm) immediately forces all outputs to 0 and the state to OFF.

## Timing
- Enable rising in OFF: MONITOR at the next edge. The first strobe falls in the SAMPLE_DIV-th MONITOR cycle.
- With defaults, the first avg_valid pulse arrives 12 cycles after entering MONITOR plus 1 cycle.
- buzzer and led rise one cycle after avg_valid. Statistics and log_level update at the same edge.
- buzzer is high for exactly ALARM_CYCLES cycles, or until the edge after stop_alarm is sampled high.
- After the alarm: one CLEAR cycle, then a fresh window starts from empty accumulators.
- log_rd_data is valid combinationally from the head while !log_empty. A pop updates it at the next edge.

## Test plan
- Ch1 constant 60, ch0/ch2 constant 10, enable = 1 -> avg_valid with avg_out = {10,60,10}; led = 3'b010; buzzer high for 100 cycles; peak = 60/ch1; last = 60/ch1; trigger_count = 1; log head {3'b010, 60}.
- Ch0 samples 49,50,51,50 -> avg 50, alarm triggers. Samples 48,49,50,50 -> avg 49 (truncated), no alarm.
- All channels at 70 -> led = 3'b111; trigger_count += 3; peak_ch = 0 (tie rule); last_ch = 2.
- stop_alarm pulsed 10 cycles into the alarm -> buzzer and led low at the next edge; CLEAR for one cycle; MONITOR resumes.
- Nine events with no reads -> log_level = 8, log_overflow = 1, the first event is still at the head. Pop and push in the same cycle while full -> level stays 8, no further overflow.
- rst_n pulsed low mid-alarm -> all outputs 0 asynchronously; after release, OFF until enable is sampled high.

Source files
------------

// File: rtl/pir_array_monitor.sv
// Multi-channel PIR motion monitor: windowed averaging, timed alarm, retained
// trigger statistics and an event-log FIFO with first-word-fall-through reads.
module pir_array_monitor #(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned SAMPLE_W     = 7,
    parameter int unsigned AVG_LOG2     = 2,
    parameter int unsigned SAMPLE_DIV   = 3,
    parameter int unsigned THRESHOLD    = 50,
    parameter int unsigned ALARM_CYCLES = 100,
    parameter int unsigned LOG_DEPTH    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              stop_alarm,
    input  logic [NUM_CH*SAMPLE_W-1:0]        sensor_data,
    output logic [NUM_CH-1:0]                 led,
    output logic                              buzzer,
    output logic [NUM_CH*SAMPLE_W-1:0]        avg_out,
    output logic                              avg_valid,
    output logic [SAMPLE_W-1:0]               peak_value,
    output logic [2:0]                        peak_ch,
    output logic [SAMPLE_W-1:0]               last_value,
    output logic [2:0]                        last_ch,
    output logic [15:0]                       trigger_count,
    input  logic                              log_rd_en,
    output logic [NUM_CH+SAMPLE_W-1:0]        log_rd_data,
    output logic                              log_empty,
    output logic [$clog2(LOG_DEPTH+1)-1:0]    log_level,
    output logic                              log_overflow
);

    localparam int unsigned ACC_W  = SAMPLE_W + AVG_LOG2;
    localparam int unsigned WIN    = 1 << AVG_LOG2;
    localparam int unsigned SDIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ACNT_W = $clog2(ALARM_CYCLES + 1);
    localparam int unsigned PTR_W  = $clog2(LOG_DEPTH);
    localparam int unsigned LVL_W  = $clog2(LOG_DEPTH + 1);
    localparam int unsigned POP_W  = $clog2(NUM_CH + 1);
    localparam int unsigned ENT_W  = NUM_CH + SAMPLE_W;

    localparam logic [1:0] S_OFF     = 2'd0;
    localparam logic [1:0] S_MONITOR = 2'd1;
    localparam logic [1:0] S_ALARM   = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [SDIV_W-1:0]          samp_cnt_q, samp_cnt_d;
    logic [WCNT_W-1:0]          win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0]           acc_q [NUM_CH];
    logic [ACC_W-1:0]           acc_d [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0] avg_q, avg_d;
    logic                       avg_valid_q, avg_valid_d;
    logic [ACNT_W-1:0]          alarm_cnt_q, alarm_cnt_d;
    logic [NUM_CH-1:0]          led_q, led_d;
    logic                       buzzer_q, buzzer_d;
    logic [SAMPLE_W-1:0]        peak_val_q, peak_val_d, last_val_q, last_val_d;
    logic [2:0]                 peak_ch_q, peak_ch_d, last_ch_q, last_ch_d;
    logic [15:0]                trig_cnt_q, trig_cnt_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]           level_q, level_d;
    logic                       ovf_q, ovf_d;
    logic [ENT_W-1:0]           log_mem [LOG_DEPTH];

    logic                       strobe_c, log_push_c, log_pop_c, log_we_c, log_full_c;
    logic [NUM_CH-1:0]          mask_c;
    logic [SAMPLE_W-1:0]        ev_max_c, last_val_c;
    logic [2:0]                 ev_ch_c, last_ch_c;
    logic [POP_W-1:0]           pop_c;
    logic [16:0]                trig_sum_c;

    // Trigger mask and event summary derived from the registered averages.
    always_comb begin : event_comb
        logic found;
        logic [SAMPLE_W-1:0] v;
        found      = 1'b0;
        mask_c     = '0;
        ev_max_c   = '0;
        ev_ch_c    = '0;
        last_val_c = '0;
        last_ch_c  = '0;
        pop_c      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v = avg_q[c*SAMPLE_W +: SAMPLE_W];
            if (v >= SAMPLE_W'(THRESHOLD)) begin
                mask_c[c]  = 1'b1;
                pop_c      = pop_c + POP_W'(1);
                last_val_c = v;
                last_ch_c  = 3'(c);
                if (!found || v > ev_max_c) begin
                    ev_max_c = v;
                    ev_ch_c  = 3'(c);
                end
                found = 1'b1;
            end
        end
    end

    assign strobe_c   = (state_q == S_MONITOR) && (samp_cnt_q == SDIV_W'(SAMPLE_DIV - 1));
    assign trig_sum_c = {1'b0, trig_cnt_q} + 17'(pop_c);

    always_comb begin : fsm_comb
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        alarm_cnt_d = alarm_cnt_q;
        led_d       = led_q;
        buzzer_d    = buzzer_q;
        peak_val_d  = peak_val_q;
        peak_ch_d   = peak_ch_q;
        last_val_d  = last_val_q;
        last_ch_d   = last_ch_q;
        trig_cnt_d  = trig_cnt_q;
        log_push_c  = 1'b0;
        case (state_q)
            S_OFF: begin
                if (enable) state_d = S_MONITOR;
            end
            S_MONITOR: begin
                samp_cnt_d = strobe_c ? '0 : samp_cnt_q + SDIV_W'(1);
                if (strobe_c) begin
                    if (win_cnt_q == WCNT_W'(WIN - 1)) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            avg_d[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(
                                (acc_q[c] + ACC_W'(sensor_data[c*SAMPLE_W +: SAMPLE_W])) >> AVG_LOG2);
                            acc_d[c] = '0;
                        end
                        win_cnt_d   = '0;
                        avg_valid_d = 1'b1;
                    end else begin
                        for (int c = 0; c < NUM_CH; c++)
                            acc_d[c] = acc_q[c] + ACC_W'(sensor_data[c*SAMPLE_W +: SAMPLE_W]);
                        win_cnt_d = win_cnt_q + WCNT_W'(1);
                    end
                end
                if (!enable) begin
                    state_d = S_CLEAR;
                end else if (avg_valid_q && (mask_c != '0)) begin
                    state_d     = S_ALARM;
                    led_d       = mask_c;
                    buzzer_d    = 1'b1;
                    alarm_cnt_d = '0;
                    trig_cnt_d  = trig_sum_c[16] ? 16'hFFFF : trig_sum_c[15:0];
                    last_val_d  = last_val_c;
                    last_ch_d   = last_ch_c;
                    log_push_c  = 1'b1;
                    if (ev_max_c > peak_val_q) begin
                        peak_val_d = ev_max_c;
                        peak_ch_d  = ev_ch_c;
                    end
                end
            end
            S_ALARM: begin
                // Operator stop and disable take priority over the duration timer.
                if (stop_alarm || !enable || (alarm_cnt_q == ACNT_W'(ALARM_CYCLES - 1))) begin
                    state_d  = S_CLEAR;
                    led_d    = '0;
                    buzzer_d = 1'b0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + ACNT_W'(1);
                end
            end
            S_CLEAR: begin
                led_d       = '0;
                buzzer_d    = 1'b0;
                samp_cnt_d  = '0;
                win_cnt_d   = '0;
                alarm_cnt_d = '0;
                for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
                state_d = enable ? S_MONITOR : S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // A full log still accepts a push when the head is popped in the same cycle.
    always_comb begin : log_comb
        log_full_c = (level_q == LVL_W'(LOG_DEPTH));
        log_pop_c  = log_rd_en && (level_q != '0);
        log_we_c   = log_push_c && (!log_full_c || log_pop_c);
        wr_ptr_d   = log_we_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = log_pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q + LVL_W'(log_we_c) - LVL_W'(log_pop_c);
        ovf_d      = ovf_q | (log_push_c && !log_we_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            samp_cnt_q  <= '0;
            win_cnt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            alarm_cnt_q <= '0;
            led_q       <= '0;
            buzzer_q    <= 1'b0;
            peak_val_q  <= '0;
            peak_ch_q   <= '0;
            last_val_q  <= '0;
            last_ch_q   <= '0;
            trig_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            alarm_cnt_q <= alarm_cnt_d;
            led_q       <= led_d;
            buzzer_q    <= buzzer_d;
            peak_val_q  <= peak_val_d;
            peak_ch_q   <= peak_ch_d;
            last_val_q  <= last_val_d;
            last_ch_q   <= last_ch_d;
            trig_cnt_q  <= trig_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (log_we_c) log_mem[wr_ptr_q] <= {mask_c, ev_max_c};
    end

    assign led           = led_q;
    assign buzzer        = buzzer_q;
    assign avg_out       = avg_q;
    assign avg_valid     = avg_valid_q;
    assign peak_value    = peak_val_q;
    assign peak_ch       = peak_ch_q;
    assign last_value    = last_val_q;
    assign last_ch       = last_ch_q;
    assign trigger_count = trig_cnt_q;
    assign log_empty     = (level_q == '0);
    assign log_rd_data   = log_empty ? '0 : log_mem[rd_ptr_q];
    assign log_level     = level_q;
    assign log_overflow  = ovf_q;

endmodule

// File: tb/tb_pir_array_monitor.sv
// Directed bench for pir_array_monitor at default parameters.
module tb_pir_array_monitor;

    logic        clk = 1'b0;
    logic        rst_n, enable, stop_alarm, log_rd_en;
    logic [20:0] sensor_data;
    logic [2:0]  led;
    logic        buzzer;
    logic [20:0] avg_out;
    logic        avg_valid;
    logic [6:0]  peak_value, last_value;
    logic [2:0]  peak_ch, last_ch;
    logic [15:0] trigger_count;
    logic [9:0]  log_rd_data;
    logic        log_empty;
    logic [3:0]  log_level;
    logic        log_overflow;

    int errors = 0;
    int checks = 0;

    pir_array_monitor dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stop_alarm(stop_alarm),
        .sensor_data(sensor_data), .led(led), .buzzer(buzzer), .avg_out(avg_out),
        .avg_valid(avg_valid), .peak_value(peak_value), .peak_ch(peak_ch),
        .last_value(last_value), .last_ch(last_ch), .trigger_count(trigger_count),
        .log_rd_en(log_rd_en), .log_rd_data(log_rd_data), .log_empty(log_empty),
        .log_level(log_level), .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pk(input logic [6:0] c2, input logic [6:0] c1, input logic [6:0] c0);
        return {c2, c1, c0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_off;
        enable = 1'b0;
        stop_alarm = 1'b0;
        tick;
        tick;
    endtask

    // From OFF: enable, then hold each word for one strobe period; stops one edge short of avg_valid.
    task automatic run_window(input logic [20:0] w0, input logic [20:0] w1,
                              input logic [20:0] w2, input logic [20:0] w3);
        enable = 1'b1;
        sensor_data = w0;
        tick;
        repeat (3) tick;
        sensor_data = w1;
        repeat (3) tick;
        sensor_data = w2;
        repeat (3) tick;
        sensor_data = w3;
        repeat (2) tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; stop_alarm = 1'b0; log_rd_en = 1'b0; sensor_data = '0;
        repeat (2) tick;
        checks++; if ({led, buzzer, avg_valid} !== 5'b0) begin errors++; $display("FAIL reset_alarm_outs: got %b expected 00000", {led, buzzer, avg_valid}); end
        checks++; if (avg_out !== 21'd0) begin errors++; $display("FAIL reset_avg_out: got %h expected 0", avg_out); end
        checks++; if ({trigger_count, peak_value, peak_ch, last_value, last_ch} !== 36'd0) begin errors++; $display("FAIL reset_stats: got %h expected 0", {trigger_count, peak_value, peak_ch, last_value, last_ch}); end
        checks++; if ({log_level, log_empty, log_overflow, log_rd_data} !== {4'd0, 1'b1, 1'b0, 10'd0}) begin errors++; $display("FAIL reset_log: level %0d empty %b ovf %b data %h", log_level, log_empty, log_overflow, log_rd_data); end
        rst_n = 1'b1;
        repeat (3) tick;
        checks++; if ({buzzer, avg_valid} !== 2'b00) begin errors++; $display("FAIL reset_idle_off: got %b expected 00", {buzzer, avg_valid}); end
    endtask

    task automatic test_basic_alarm;
        int hi;
        run_window(pk(10, 60, 10), pk(10, 60, 10), pk(10, 60, 10), pk(10, 60, 10));
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", avg_valid); end
        tick;
        checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", avg_valid); end
        checks++; if (avg_out !== pk(10, 60, 10)) begin errors++; $display("FAIL basic_avg: got %h expected %h", avg_out, pk(10, 60, 10)); end
        tick;
        checks++; if ({buzzer, led, avg_valid} !== 5'b1_010_0) begin errors++; $display("FAIL basic_alarm_outs: got %b expected 10100", {buzzer, led, avg_valid}); end
        checks++; if (trigger_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", trigger_count); end
        checks++; if ({peak_value, peak_ch, last_value, last_ch} !== {7'd60, 3'd1, 7'd60, 3'd1}) begin errors++; $display("FAIL basic_peak_last: got %0d/%0d %0d/%0d expected 60/1 60/1", peak_value, peak_ch, last_value, last_ch); end
        checks++; if ({log_level, log_rd_data} !== {4'd1, 3'b010, 7'd60}) begin errors++; $display("FAIL basic_log: level %0d data %h expected 1 %h", log_level, log_rd_data, {3'b010, 7'd60}); end
        hi = 1;
        for (int i = 0; i < 200 && buzzer === 1'b1; i++) begin
            tick;
            if (buzzer === 1'b1) hi++;
        end
        checks++; if (hi != 100) begin errors++; $display("FAIL basic_buzz_len: got %0d expected 100", hi); end
        checks++; if (led !== 3'b000) begin errors++; $display("FAIL basic_led_clear: got %b expected 000", led); end
        go_off;
        checks++; if (avg_out !== pk(10, 60, 10)) begin errors++; $display("FAIL basic_avg_held: got %h expected %h", avg_out, pk(10, 60, 10)); end
    endtask

    task automatic test_threshold;
        run_window(pk(0, 0, 49), pk(0, 0, 50), pk(0, 0, 51), pk(0, 0, 50));
        tick;
        checks++; if ({avg_valid, avg_out} !== {1'b1, pk(0, 0, 50)}) begin errors++; $display("FAIL thr_avg50: got %b %h expected 1 %h", avg_valid, avg_out, pk(0, 0, 50)); end
        tick;
        checks++; if ({buzzer, led} !== 4'b1_001) begin errors++; $display("FAIL thr_alarm: got %b expected 1001", {buzzer, led}); end
        checks++; if ({trigger_count, last_value, last_ch, peak_value, peak_ch} !== {16'd2, 7'd50, 3'd0, 7'd60, 3'd1}) begin errors++; $display("FAIL thr_stats: count %0d last %0d/%0d peak %0d/%0d", trigger_count, last_value, last_ch, peak_value, peak_ch); end
        go_off;
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL thr_disable_stop: got %b expected 0", buzzer); end
        run_window(pk(0, 0, 48), pk(0, 0, 49), pk(0, 0, 50), pk(0, 0, 50));
        tick;
        checks++; if (avg_out !== pk(0, 0, 49)) begin errors++; $display("FAIL thr_avg49: got %h expected %h", avg_out, pk(0, 0, 49)); end
        tick;
        checks++; if ({buzzer, trigger_count, log_level} !== {1'b0, 16'd2, 4'd2}) begin errors++; $display("FAIL thr_no_alarm: buzzer %b count %0d level %0d", buzzer, trigger_count, log_level); end
        go_off;
    endtask

    task automatic test_all_channels_stop;
        run_window(pk(70, 70, 70), pk(70, 70, 70), pk(70, 70, 70), pk(70, 70, 70));
        tick;
        tick;
        checks++; if ({buzzer, led} !== 4'b1_111) begin errors++; $display("FAIL all_led: got %b expected 1111", {buzzer, led}); end
        checks++; if ({trigger_count, peak_value, peak_ch, last_value, last_ch} !== {16'd5, 7'd70, 3'd0, 7'd70, 3'd2}) begin errors++; $display("FAIL all_stats: count %0d peak %0d/%0d last %0d/%0d", trigger_count, peak_value, peak_ch, last_value, last_ch); end
        repeat (9) tick;
        checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL stop_pre: got %b expected 1", buzzer); end
        stop_alarm = 1'b1;
        sensor_data = pk(20, 20, 20);
        tick;
        stop_alarm = 1'b0;
        checks++; if ({buzzer, led} !== 4'b0) begin errors++; $display("FAIL stop_outs: got %b expected 0000", {buzzer, led}); end
        repeat (12) tick;
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL stop_resume_early: got %b expected 0", avg_valid); end
        tick;
        checks++; if ({avg_valid, avg_out} !== {1'b1, pk(20, 20, 20)}) begin errors++; $display("FAIL stop_resume: got %b %h expected 1 %h", avg_valid, avg_out, pk(20, 20, 20)); end
        go_off;
    endtask

    task automatic test_log_overflow;
        for (int k = 0; k < 5; k++) begin
            run_window(pk(0, 55, 0), pk(0, 55, 0), pk(0, 55, 0), pk(0, 55, 0));
            tick;
            tick;
            go_off;
        end
        checks++; if ({log_level, log_overflow, trigger_count} !== {4'd8, 1'b0, 16'd10}) begin errors++; $display("FAIL log_full: level %0d ovf %b count %0d expected 8 0 10", log_level, log_overflow, trigger_count); end
        run_window(pk(0, 0, 52), pk(0, 0, 52), pk(0, 0, 52), pk(0, 0, 52));
        tick;
        tick;
        go_off;
        checks++; if ({log_level, log_overflow} !== {4'd8, 1'b1}) begin errors++; $display("FAIL log_ovf: level %0d ovf %b expected 8 1", log_level, log_overflow); end
        checks++; if (log_rd_data !== {3'b010, 7'd60}) begin errors++; $display("FAIL log_head_kept: got %h expected %h", log_rd_data, {3'b010, 7'd60}); end
        checks++; if ({trigger_count, last_value, last_ch, peak_value, peak_ch} !== {16'd11, 7'd52, 3'd0, 7'd70, 3'd0}) begin errors++; $display("FAIL log_ovf_stats: count %0d last %0d/%0d peak %0d/%0d", trigger_count, last_value, last_ch, peak_value, peak_ch); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_log [8];
        exp_log[0] = {3'b001, 7'd50};
        exp_log[1] = {3'b111, 7'd70};
        for (int i = 2; i < 7; i++) exp_log[i] = {3'b010, 7'd55};
        exp_log[7] = {3'b100, 7'd65};
        run_window(pk(65, 0, 0), pk(65, 0, 0), pk(65, 0, 0), pk(65, 0, 0));
        tick;
        log_rd_en = 1'b1;
        tick;
        log_rd_en = 1'b0;
        checks++; if ({log_level, log_rd_data} !== {4'd8, 3'b001, 7'd50}) begin errors++; $display("FAIL b2b_level_head: level %0d data %h expected 8 %h", log_level, log_rd_data, {3'b001, 7'd50}); end
        checks++; if ({buzzer, trigger_count, last_value, last_ch} !== {1'b1, 16'd12, 7'd65, 3'd2}) begin errors++; $display("FAIL b2b_stats: buzzer %b count %0d last %0d/%0d", buzzer, trigger_count, last_value, last_ch); end
        go_off;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({log_empty, log_rd_data} !== {1'b0, exp_log[i]}) begin errors++; $display("FAIL drain_%0d: empty %b data %h expected 0 %h", i, log_empty, log_rd_data, exp_log[i]); end
            log_rd_en = 1'b1;
            tick;
            log_rd_en = 1'b0;
        end
        checks++; if ({log_empty, log_level} !== {1'b1, 4'd0}) begin errors++; $display("FAIL drain_empty: empty %b level %0d expected 1 0", log_empty, log_level); end
        log_rd_en = 1'b1;
        tick;
        log_rd_en = 1'b0;
        checks++; if ({log_empty, log_level, log_overflow} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL pop_empty: empty %b level %0d ovf %b expected 1 0 1", log_empty, log_level, log_overflow); end
    endtask

    task automatic test_reset_mid_alarm;
        int seen;
        run_window(pk(0, 60, 0), pk(0, 60, 0), pk(0, 60, 0), pk(0, 60, 0));
        tick;
        tick;
        repeat (5) tick;
        checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL rst_pre_alarm: got %b expected 1", buzzer); end
        rst_n = 1'b0;
        #1;
        checks++; if ({buzzer, led, avg_valid, avg_out} !== 26'd0) begin errors++; $display("FAIL rst_async_outs: got %h expected 0", {buzzer, led, avg_valid, avg_out}); end
        checks++; if ({trigger_count, peak_value, last_value, log_level, log_overflow, log_empty} !== {16'd0, 7'd0, 7'd0, 4'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL rst_async_stats: count %0d peak %0d last %0d level %0d ovf %b empty %b", trigger_count, peak_value, last_value, log_level, log_overflow, log_empty); end
        enable = 1'b0;
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (avg_valid === 1'b1 || buzzer === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_stays_off: got %0d active cycles expected 0", seen); end
        run_window(pk(0, 60, 0), pk(0, 60, 0), pk(0, 60, 0), pk(0, 60, 0));
        tick;
        checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL rst_restart_valid: got %b expected 1", avg_valid); end
        tick;
        checks++; if ({buzzer, trigger_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL rst_restart_count: buzzer %b count %0d expected 1 1", buzzer, trigger_count); end
        go_off;
    endtask

    initial begin
        test_reset;
        test_basic_alarm;
        test_threshold;
        test_all_channels_stop;
        test_log_overflow;
        test_back_to_back;
        test_reset_mid_alarm;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
